// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - step codes, direction constants and quadrature transition lookup
package enc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // {A,B} forward order is 00 -> 01 -> 11 -> 10 -> 00; both bits flipping is illegal.
  function automatic step_t step_of(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_t s;
    case ({prev_ab, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ERR;
      default:                            s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/filtro_entrada.sv
// rtl/filtro_entrada.sv - 2-FF synchronizer plus FILT_LEN-sample glitch filter for one encoder pin
module filtro_entrada #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic ready
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          s1;
  logic          s2;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;

  // ready rises once the synchronizer holds a real sample; that sample seeds dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      fill  <= 2'd0;
      cnt   <= '0;
      dout  <= 1'b0;
      ready <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (!ready) begin
        cnt <= '0;
        if (fill == 2'd2) begin
          dout  <= s2;
          ready <= 1'b1;
        end else begin
          fill <= fill + 2'd1;
        end
      end else if (s2 != dout) begin
        if (cnt == CW'(FILT_LEN - 1)) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lector_encoder.sv
// rtl/lector_encoder.sv - 4x quadrature decoder with position, windowed velocity, direction and error count
module lector_encoder
  import enc_pkg::*;
#(
  parameter int POS_W         = 16,
  parameter int VEL_W         = 12,
  parameter int FILT_LEN      = 4,
  parameter int WINDOW_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr_pos,
  output logic [POS_W-1:0] position,
  output logic [VEL_W-1:0] velocity,
  output logic             vel_valid,
  output logic             dir,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam int WCW = $clog2(WINDOW_CYCLES);
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VMIN = -VMAX;

  logic                    a_f, b_f, a_rdy, b_rdy;
  logic                    primed;
  logic [1:0]              prev_ab;
  logic [1:0]              cur_ab;
  step_t                   step;
  logic [WCW-1:0]          wcnt;
  logic                    terminal;
  logic signed [VEL_W-1:0] acc;
  logic signed [VEL_W-1:0] acc_next;

  filtro_entrada #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din(enc_a), .dout(a_f), .ready(a_rdy)
  );
  filtro_entrada #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din(enc_b), .dout(b_f), .ready(b_rdy)
  );

  assign cur_ab   = {a_f, b_f};
  assign terminal = (wcnt == WCW'(WINDOW_CYCLES - 1));

  always_comb begin
    step = STEP_NONE;
    if (primed && (cur_ab != prev_ab)) step = step_of(prev_ab, cur_ab);
  end

  // Symmetric saturation keeps the accumulator from ever wrapping.
  always_comb begin
    acc_next = acc;
    if (step == STEP_FWD && acc != VMAX)      acc_next = acc + VEL_W'(1);
    else if (step == STEP_REV && acc != VMIN) acc_next = acc - VEL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed    <= 1'b0;
      prev_ab   <= 2'b00;
      position  <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
      wcnt      <= '0;
      acc       <= '0;
    end else begin
      err       <= (step == STEP_ERR);
      vel_valid <= terminal;

      if (primed) begin
        prev_ab <= cur_ab;
      end else if (a_rdy && b_rdy) begin
        prev_ab <= cur_ab;
        primed  <= 1'b1;
      end

      if (step == STEP_ERR && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (step == STEP_FWD)      dir <= DIR_FWD;
      else if (step == STEP_REV) dir <= DIR_REV;

      if (clr_pos)               position <= '0;
      else if (step == STEP_FWD) position <= position + POS_W'(1);
      else if (step == STEP_REV) position <= position - POS_W'(1);

      // A step in the terminal cycle still belongs to the closing window.
      if (terminal) begin
        wcnt     <= '0;
        velocity <= acc_next;
        acc      <= '0;
      end else begin
        wcnt <= wcnt + WCW'(1);
        acc  <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_lector_encoder.sv
// tb/tb_lector_encoder.sv - scoreboard bench for lector_encoder with directed steps
module tb_lector_encoder;

  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        clr_pos = 1'b0;
  logic [15:0] position;
  logic [11:0] velocity;
  logic        vel_valid;
  logic        dir;
  logic        err;
  logic [7:0]  err_count;

  typedef struct {
    int          cyc;
    logic [15:0] pos;
    logic        dir;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gidx = 0;
  logic [15:0] pos_m = 16'h0;
  int          win_cnt[0:63];
  int          vel_checks = 0;
  int          err_seen = 0;
  logic [15:0] last_pos = 16'h0;
  int          vc0;

  lector_encoder #(
    .POS_W(16), .VEL_W(12), .FILT_LEN(4), .WINDOW_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr_pos(clr_pos),
    .position(position), .velocity(velocity), .vel_valid(vel_valid),
    .dir(dir), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] gray(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Position scoreboard: every position change must match the next queued step.
  always @(negedge clk) begin : pos_mon
    exp_t e;
    if (rst) begin
      last_pos = 16'h0;
    end else if (position !== last_pos) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pos_unexpected: observed %0h expected no change from %0h", position, last_pos);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pos", {16'h0, position}, {16'h0, e.pos});
        chk("dir_at_step", {31'h0, dir}, {31'h0, e.dir});
        chk("latency_cyc", cyc, e.cyc);
      end
      last_pos = position;
    end
  end

  always @(negedge clk) begin : vel_mon
    logic [11:0] vexp;
    int k;
    if (!rst && vel_valid) begin
      k = cyc / W;
      vexp = 12'(win_cnt[k % 64]);
      chk("vel_slot", cyc % W, 0);
      chk("velocity", {20'h0, velocity}, {20'h0, vexp});
      vel_checks++;
    end
    if (!rst && err) err_seen++;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_position"},  {16'h0, position}, 32'h0);
    chk({tag, "_velocity"},  {20'h0, velocity}, 32'h0);
    chk({tag, "_vel_valid"}, {31'h0, vel_valid}, 32'h0);
    chk({tag, "_dir"},       {31'h0, dir}, 32'h0);
    chk({tag, "_err"},       {31'h0, err}, 32'h0);
    chk({tag, "_err_count"}, {24'h0, err_count}, 32'h0);
  endtask

  task automatic do_reset(input logic [1:0] ab0, input int g0, input bit check);
    rst = 1'b1;
    clr_pos = 1'b0;
    enc_a = ab0[1];
    enc_b = ab0[0];
    #1;
    if (check) check_zero("reset");
    pos_m = 16'h0;
    gidx = g0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) win_cnt[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive one Gray step at the current negedge; expected landing is 7 clk later.
  task automatic step(input bit fwd, input int gap, input bit clr);
    exp_t e;
    logic [1:0] ab;
    gidx = fwd ? (gidx + 1) % 4 : (gidx + 3) % 4;
    ab = gray(gidx);
    enc_a = ab[1];
    enc_b = ab[0];
    pos_m = clr ? 16'h0 : (fwd ? pos_m + 16'd1 : pos_m - 16'd1);
    e.cyc = cyc + 7;
    e.pos = pos_m;
    e.dir = fwd;
    win_cnt[((e.cyc + W - 1) / W) % 64] += fwd ? 1 : -1;
    exp_q.push_back(e);
    if (clr) begin
      repeat (6) @(negedge clk);
      clr_pos = 1'b1;
      @(negedge clk);
      clr_pos = 1'b0;
      repeat (gap - 7) @(negedge clk);
    end else begin
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic both_toggle(input int gap);
    logic [1:0] ab;
    gidx = (gidx + 2) % 4;
    ab = gray(gidx);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state, then 8 forward steps 20 clk apart
    @(negedge clk);
    do_reset(2'b00, 0, 1'b1);
    wait_cyc(10);
    for (int i = 0; i < 8; i++) step(1'b1, 20, 1'b0);
    wait_idle("t1");
    chk("t1_position", {16'h0, position}, 32'd8);
    chk("t1_dir", {31'h0, dir}, 32'd1);
    chk("t1_err_count", {24'h0, err_count}, 32'd0);

    // 2: 10 forward then 3 reverse; then a single reverse step from zero
    do_reset(2'b00, 0, 1'b0);
    wait_cyc(10);
    for (int i = 0; i < 10; i++) step(1'b1, 20, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 20, 1'b0);
    wait_idle("t2");
    chk("t2_position", {16'h0, position}, 32'd7);
    chk("t2_dir", {31'h0, dir}, 32'd0);
    do_reset(2'b00, 0, 1'b0);
    wait_cyc(10);
    step(1'b0, 20, 1'b0);
    wait_idle("t2b");
    chk("t2_wrap_down", {16'h0, position}, 32'h0000FFFF);

    // 3: short glitch on A is rejected; simultaneous A/B change is an error
    do_reset(2'b00, 0, 1'b0);
    wait_cyc(10);
    err_seen = 0;
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_glitch_position", {16'h0, position}, 32'd0);
    chk("t3_glitch_err_count", {24'h0, err_count}, 32'd0);
    chk("t3_glitch_err_seen", err_seen, 0);
    both_toggle(20);
    chk("t3_err_pulses", err_seen, 1);
    chk("t3_err_count", {24'h0, err_count}, 32'd1);
    chk("t3_err_position", {16'h0, position}, 32'd0);
    chk("t3_err_dir", {31'h0, dir}, 32'd0);

    // 4: velocity windows, including a step landing in the terminal cycle
    do_reset(2'b00, 0, 1'b0);
    vc0 = vel_checks;
    wait_cyc(10);
    for (int i = 0; i < 5; i++) step(1'b1, 10, 1'b0);
    wait_cyc(293);
    step(1'b1, 1, 1'b0);
    wait_idle("t4");
    wait_cyc(410);
    chk("t4_window_count", vel_checks - vc0, 4);
    chk("t4_last_velocity", {20'h0, velocity}, 32'd0);

    // 5: clear at position 42 coincident with a step
    do_reset(2'b00, 0, 1'b0);
    wait_cyc(5);
    for (int i = 0; i < 42; i++) step(1'b1, 8, 1'b0);
    wait_idle("t5a");
    chk("t5_pre_position", {16'h0, position}, 32'd42);
    step(1'b1, 12, 1'b1);
    wait_idle("t5b");
    chk("t5_cleared", {16'h0, position}, 32'd0);
    chk("t5_dir", {31'h0, dir}, 32'd1);
    wait_cyc(410);

    // 6: reset mid-window, then re-prime from a non-zero pin state
    do_reset(2'b00, 0, 1'b0);
    wait_cyc(10);
    for (int i = 0; i < 12; i++) step(1'b1, 10, 1'b0);
    for (int i = 0; i < 3; i++) both_toggle(12);
    wait_idle("t6a");
    chk("t6_pre_position", {16'h0, position}, 32'd12);
    chk("t6_pre_err_count", {24'h0, err_count}, 32'd3);
    do_reset(2'b11, 2, 1'b1);
    repeat (20) @(negedge clk);
    chk("t6_primed_position", {16'h0, position}, 32'd0);
    chk("t6_primed_err_count", {24'h0, err_count}, 32'd0);
    chk("t6_primed_dir", {31'h0, dir}, 32'd0);
    step(1'b1, 20, 1'b0);
    wait_idle("t6b");
    chk("t6_after_prime", {16'h0, position}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
